if_fetch_unit: RTL and testbench

Instruction fetch stage feeding the decode stage of the 5-stage MIPS pipeline. Holds the fetch PC, runs a variable-latency request/acknowledge handshake with instruction memory, and drives the IF/ID pipeline register (`Instruction`, `PC`, `Valid`). It also applies hazard freezes and taken-branch redirects/flushes. Bubbles are inserted as `32'h0` (`sll $0,$0,0`), so decode needs no valid qualifier.

---
 rtl/if_fetch_unit_if.sv | 22 ++
 rtl/if_fetch_unit.sv | 142 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
// The fetch unit is the master; the memory (or bench) is the slave.
interface if_fetch_unit_if;
  logic        IMEM_Req;
  logic [31:0] IMEM_Addr;
  logic        IMEM_Ack;
  logic [31:0] IMEM_Data;

  modport master (
    output IMEM_Req,
    output IMEM_Addr,
    input  IMEM_Ack,
    input  IMEM_Data
  );

  modport slave (
    input  IMEM_Req,
    input  IMEM_Addr,
    output IMEM_Ack,
    output IMEM_Data
  );
endinterface

// File: rtl/if_fetch_unit.sv
// MIPS IF stage: fetch PC, variable-latency imem handshake, IF/ID register with freeze/flush.
// Optional macro IF_STALL_CNT_EN adds a saturating 16-bit Stall_Count output.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Freeze,
  input  logic                 Br_Taken,
  input  logic [31:0]          Br_Addr,
  if_fetch_unit_if.master      imem,
  output logic [31:0]          Instruction,
  output logic [31:0]          PC,
  output logic                 Valid
`ifdef IF_STALL_CNT_EN
  ,
  output logic [15:0]          Stall_Count
`endif
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_fpc;
  logic [31:0] r_tgt;
  logic [31:0] r_buf;
  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic        r_valid;

  logic [31:0] w_br_addr;
  logic [31:0] w_fpc_inc;
  logic        w_ack;
  logic        w_load;
  logic [31:0] w_load_word;
  logic        w_bubble;

  assign w_br_addr = Br_Addr & 32'hFFFF_FFFC;
  assign w_fpc_inc = r_fpc + 32'd4;
  assign w_ack     = imem.IMEM_Ack;

  // Request is decoded from state; HOLD parks a word so the bus stays idle.
  assign imem.IMEM_Req  = !rst && (r_state != HOLD);
  assign imem.IMEM_Addr = r_fpc;

  assign Instruction = r_instr;
  assign PC          = r_pc;
  assign Valid       = r_valid;

  always_comb begin
    w_load      = 1'b0;
    w_load_word = imem.IMEM_Data;
    case (r_state)
      FETCH: begin
        w_load      = w_ack && !Br_Taken && !Freeze;
        w_load_word = imem.IMEM_Data;
      end
      HOLD: begin
        w_load      = !Br_Taken && !Freeze;
        w_load_word = r_buf;
      end
      default: begin
        w_load      = 1'b0;
        w_load_word = imem.IMEM_Data;
      end
    endcase
    // A taken branch flushes IF/ID even under Freeze.
    w_bubble = Br_Taken || (!w_load && !Freeze);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH;
      r_fpc   <= RESET_PC & 32'hFFFF_FFFC;
      r_tgt   <= 32'h0;
      r_buf   <= 32'h0;
      r_instr <= 32'h0;
      r_pc    <= 32'h0;
      r_valid <= 1'b0;
    end else begin
      if (w_load) begin
        r_instr <= w_load_word;
        r_pc    <= w_fpc_inc;
        r_valid <= 1'b1;
        r_fpc   <= w_fpc_inc;
      end else if (w_bubble) begin
        r_instr <= 32'h0;
        r_valid <= 1'b0;
      end

      case (r_state)
        FETCH: begin
          if (Br_Taken && w_ack) begin
            r_fpc <= w_br_addr;
          end else if (Br_Taken) begin
            r_tgt   <= w_br_addr;
            r_state <= DRAIN;
          end else if (w_ack && Freeze) begin
            r_buf   <= imem.IMEM_Data;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (Br_Taken) begin
            r_fpc   <= w_br_addr;
            r_state <= FETCH;
          end else if (!Freeze) begin
            r_state <= FETCH;
          end
        end
        DRAIN: begin
          // The outstanding word belongs to the squashed path; the newest target wins.
          if (w_ack) begin
            r_fpc   <= Br_Taken ? w_br_addr : r_tgt;
            r_state <= FETCH;
          end else if (Br_Taken) begin
            r_tgt <= w_br_addr;
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end

`ifdef IF_STALL_CNT_EN
  logic [15:0] r_stall_cnt;
  assign Stall_Count = r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= 16'h0;
    end else if (!w_load && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table, then random memory latency,
// freezes and branches checked against a queue-based transaction model.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        Freeze;
  logic        Br_Taken;
  logic [31:0] Br_Addr;
  logic [31:0] Instruction;
  logic [31:0] PC;
  logic        Valid;

  if_fetch_unit_if imem_bus ();

  if_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk         (clk),
    .rst         (rst),
    .Freeze      (Freeze),
    .Br_Taken    (Br_Taken),
    .Br_Addr     (Br_Addr),
    .imem        (imem_bus),
    .Instruction (Instruction),
    .PC          (PC),
    .Valid       (Valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        frz;
    logic        br;
    logic [31:0] ba;
    logic        ack;
    logic        pre_req;
    logic [31:0] pre_addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
  } vec_t;

  function automatic vec_t mk(input logic frz, input logic br, input logic [31:0] ba,
                              input logic ack, input logic pre_req, input logic [31:0] pre_addr,
                              input logic valid, input logic [31:0] instr, input logic [31:0] pc);
    vec_t v;
    v.frz = frz; v.br = br; v.ba = ba; v.ack = ack;
    v.pre_req = pre_req; v.pre_addr = pre_addr;
    v.valid = valid; v.instr = instr; v.pc = pc;
    return v;
  endfunction

  vec_t vt[26];

  // Transaction model: fetch pointer, parked words, and a squash mark for an in-flight fetch.
  logic [31:0] m_pc, m_tgt;
  bit          m_squash;
  logic [31:0] m_hold[$];
  logic [31:0] exp_instr, exp_pc;
  logic        exp_valid;
  int          mem_wait;

  task automatic model_reset();
    m_pc = 32'h100; m_tgt = 32'h0; m_squash = 0; m_hold.delete();
    exp_instr = 32'h0; exp_pc = 32'h0; exp_valid = 1'b0;
    mem_wait = -1;
  endtask

  task automatic model_step(input logic frz, input logic br, input logic [31:0] ba, input logic ack);
    logic [31:0] ba_al;
    logic [31:0] word;
    bit got;
    ba_al = ba & 32'hFFFF_FFFC;
    got = 0;
    word = 32'h0;
    if (m_hold.size() > 0) begin
      if (br) begin
        m_hold.delete();
        m_pc = ba_al;
      end else if (!frz) begin
        word = m_hold.pop_front();
        got = 1;
      end
    end else if (ack) begin
      if (br || m_squash) begin
        m_pc = br ? ba_al : m_tgt;
        m_squash = 0;
      end else if (frz) begin
        m_hold.push_back(mem_word(m_pc));
      end else begin
        word = mem_word(m_pc);
        got = 1;
      end
    end else if (br) begin
      m_squash = 1;
      m_tgt = ba_al;
    end
    if (got) begin
      m_pc = m_pc + 32'd4;
      exp_instr = word; exp_pc = m_pc; exp_valid = 1'b1;
    end else if (br || !frz) begin
      exp_instr = 32'h0; exp_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    Freeze = 1'b0; Br_Taken = 1'b0; Br_Addr = 32'h0;
    imem_bus.IMEM_Ack = 1'b0; imem_bus.IMEM_Data = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("req_in_reset", {31'h0, imem_bus.IMEM_Req}, 32'h0);
    @(posedge clk);
    #1;
    check("reset_instr", Instruction, 32'h0);
    check("reset_pc", PC, 32'h0);
    check("reset_valid", {31'h0, Valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    // Directed table; RESET_PC = 0x100.
    vt[0]  = mk(0,0,32'h0,        1, 1,32'h100,       1, mem_word(32'h100), 32'h104);
    vt[1]  = mk(0,0,32'h0,        1, 1,32'h104,       1, mem_word(32'h104), 32'h108);
    vt[2]  = mk(0,0,32'h0,        0, 1,32'h108,       0, 32'h0,             32'h108);
    vt[3]  = mk(0,0,32'h0,        0, 1,32'h108,       0, 32'h0,             32'h108);
    vt[4]  = mk(0,0,32'h0,        1, 1,32'h108,       1, mem_word(32'h108), 32'h10C);
    vt[5]  = mk(1,0,32'h0,        0, 1,32'h10C,       1, mem_word(32'h108), 32'h10C);
    vt[6]  = mk(1,0,32'h0,        1, 1,32'h10C,       1, mem_word(32'h108), 32'h10C);
    vt[7]  = mk(1,0,32'h0,        0, 0,32'h10C,       1, mem_word(32'h108), 32'h10C);
    vt[8]  = mk(1,0,32'h0,        0, 0,32'h10C,       1, mem_word(32'h108), 32'h10C);
    vt[9]  = mk(0,0,32'h0,        0, 0,32'h10C,       1, mem_word(32'h10C), 32'h110);
    vt[10] = mk(0,1,32'h200,      0, 1,32'h110,       0, 32'h0,             32'h110);
    vt[11] = mk(0,0,32'h0,        0, 1,32'h110,       0, 32'h0,             32'h110);
    vt[12] = mk(0,0,32'h0,        1, 1,32'h110,       0, 32'h0,             32'h110);
    vt[13] = mk(0,0,32'h0,        1, 1,32'h200,       1, mem_word(32'h200), 32'h204);
    vt[14] = mk(1,1,32'h203,      1, 1,32'h204,       0, 32'h0,             32'h204);
    vt[15] = mk(0,0,32'h0,        1, 1,32'h200,       1, mem_word(32'h200), 32'h204);
    vt[16] = mk(0,1,32'hFFFF_FFFC,1, 1,32'h204,       0, 32'h0,             32'h204);
    vt[17] = mk(0,0,32'h0,        1, 1,32'hFFFF_FFFC, 1, mem_word(32'hFFFF_FFFC), 32'h0);
    vt[18] = mk(0,0,32'h0,        0, 1,32'h0,         0, 32'h0,             32'h0);
    vt[19] = mk(1,0,32'h0,        1, 1,32'h0,         0, 32'h0,             32'h0);
    vt[20] = mk(0,1,32'h300,      0, 0,32'h0,         0, 32'h0,             32'h0);
    vt[21] = mk(0,0,32'h0,        1, 1,32'h300,       1, mem_word(32'h300), 32'h304);
    vt[22] = mk(0,1,32'h400,      0, 1,32'h304,       0, 32'h0,             32'h304);
    vt[23] = mk(1,1,32'h500,      0, 1,32'h304,       0, 32'h0,             32'h304);
    vt[24] = mk(1,0,32'h0,        1, 1,32'h304,       0, 32'h0,             32'h304);
    vt[25] = mk(0,0,32'h0,        1, 1,32'h500,       1, mem_word(32'h500), 32'h504);

    do_reset();
    for (int i = 0; i < 26; i++) begin
      Freeze = vt[i].frz;
      Br_Taken = vt[i].br;
      Br_Addr = vt[i].ba;
      imem_bus.IMEM_Ack = vt[i].ack;
      imem_bus.IMEM_Data = vt[i].ack ? mem_word(vt[i].pre_addr) : 32'hDEAD_BEEF;
      check($sformatf("vec%0d_req", i), {31'h0, imem_bus.IMEM_Req}, {31'h0, vt[i].pre_req});
      check($sformatf("vec%0d_addr", i), imem_bus.IMEM_Addr, vt[i].pre_addr);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_valid", i), {31'h0, Valid}, {31'h0, vt[i].valid});
      check($sformatf("vec%0d_instr", i), Instruction, vt[i].instr);
      check($sformatf("vec%0d_pc", i), PC, vt[i].pc);
      $display("vec %0d: frz=%0b br=%0b ack=%0b -> valid=%0b instr=%h pc=%h",
               i, vt[i].frz, vt[i].br, vt[i].ack, Valid, Instruction, PC);
      @(negedge clk);
      #1;
    end

    // Randomized phase against the transaction model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic frz, br, ack;
      logic [31:0] ba;
      check("rnd_req", {31'h0, imem_bus.IMEM_Req}, {31'h0, (m_hold.size() == 0)});
      check("rnd_addr", imem_bus.IMEM_Addr, m_pc);
      check("rnd_valid", {31'h0, Valid}, {31'h0, exp_valid});
      check("rnd_instr", Instruction, exp_instr);
      check("rnd_pc", PC, exp_pc);
      if (Valid) $display("rnd cycle %0d: delivered instr=%h pc=%h", c, Instruction, PC);

      frz = ($urandom_range(0, 9) < 3);
      br  = ($urandom_range(0, 9) == 0);
      ba  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      ack = 1'b0;
      if (imem_bus.IMEM_Req) begin
        if (mem_wait < 0) mem_wait = $urandom_range(0, 3);
        if (mem_wait == 0) begin
          ack = 1'b1;
          mem_wait = -1;
        end else begin
          mem_wait--;
        end
      end
      Freeze = frz;
      Br_Taken = br;
      Br_Addr = ba;
      imem_bus.IMEM_Ack = ack;
      imem_bus.IMEM_Data = ack ? mem_word(imem_bus.IMEM_Addr) : $urandom;
      model_step(frz, br, ba, ack);
      @(negedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
